// File: rtl/seg_pkg.sv
// Shared segment/anode polarity constants and digit patterns for the scan driver.
// Hex glyphs exist only when SEG_SCAN_HEX_DECODE_EN is defined.
package seg_pkg;

  localparam logic SEG_ON  = 1'b0;
  localparam logic SEG_OFF = 1'b1;
  localparam logic AN_ON   = 1'b0;
  localparam logic AN_OFF  = 1'b1;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [6:0] SEG_DARK  = 7'h7F;

  // Patterns are a..g, active-low
  localparam logic [6:0] SEG_PAT_0 = 7'b0000001;
  localparam logic [6:0] SEG_PAT_1 = 7'b1001111;
  localparam logic [6:0] SEG_PAT_2 = 7'b0010010;
  localparam logic [6:0] SEG_PAT_3 = 7'b0000110;
  localparam logic [6:0] SEG_PAT_4 = 7'b1001100;
  localparam logic [6:0] SEG_PAT_5 = 7'b0100100;
  localparam logic [6:0] SEG_PAT_6 = 7'b0100000;
  localparam logic [6:0] SEG_PAT_7 = 7'b0001111;
  localparam logic [6:0] SEG_PAT_8 = 7'b0000000;
  localparam logic [6:0] SEG_PAT_9 = 7'b0000100;

`ifdef SEG_SCAN_HEX_DECODE_EN
  localparam logic [6:0] SEG_PAT_A = 7'b0001000;
  localparam logic [6:0] SEG_PAT_B = 7'b1100000;
  localparam logic [6:0] SEG_PAT_C = 7'b0110001;
  localparam logic [6:0] SEG_PAT_D = 7'b1000010;
  localparam logic [6:0] SEG_PAT_E = 7'b0110000;
  localparam logic [6:0] SEG_PAT_F = 7'b0111000;
`endif

  function automatic logic [7:0] seg_word(input logic [6:0] pat, input logic dp);
    return {pat, dp ? SEG_ON : SEG_OFF};
  endfunction

endpackage

// File: rtl/seg_nibble_decode.sv
// Combinational nibble-to-segment decode with decimal point and blanking.
// SEG_SCAN_HEX_DECODE_EN adds A..F glyphs; otherwise codes 10..15 go fully dark.
module seg_nibble_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  input  logic       blank,
  output logic [7:0] seg_c
);

  logic [6:0] pat_c;
  logic       known_c;

  always_comb begin
    pat_c   = SEG_DARK;
    known_c = 1'b1;
    case (nibble)
      4'h0: pat_c = SEG_PAT_0;
      4'h1: pat_c = SEG_PAT_1;
      4'h2: pat_c = SEG_PAT_2;
      4'h3: pat_c = SEG_PAT_3;
      4'h4: pat_c = SEG_PAT_4;
      4'h5: pat_c = SEG_PAT_5;
      4'h6: pat_c = SEG_PAT_6;
      4'h7: pat_c = SEG_PAT_7;
      4'h8: pat_c = SEG_PAT_8;
      4'h9: pat_c = SEG_PAT_9;
`ifdef SEG_SCAN_HEX_DECODE_EN
      4'hA: pat_c = SEG_PAT_A;
      4'hB: pat_c = SEG_PAT_B;
      4'hC: pat_c = SEG_PAT_C;
      4'hD: pat_c = SEG_PAT_D;
      4'hE: pat_c = SEG_PAT_E;
      4'hF: pat_c = SEG_PAT_F;
`endif
      default: known_c = 1'b0;
    endcase
  end

  // Undecodable codes drop the dp too; a blanked leading zero keeps it
  always_comb begin
    seg_c = SEG_BLANK;
    if (!known_c)   seg_c = SEG_BLANK;
    else if (blank) seg_c = seg_word(SEG_DARK, dp);
    else            seg_c = seg_word(pat_c, dp);
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed 7-segment scan driver with frame-synchronous shadow load.
// Define SEG_SCAN_HEX_DECODE_EN to display nibbles 10..15 as A..F.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    lzb,
  input  logic                    upd_req,
  output logic                    upd_ack,
  output logic [7:0]              seg,
  output logic [NUM_DIGITS-1:0]   an
);

  localparam int unsigned DIV_W = $clog2(REFRESH_DIV);
  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned DIG_W = 4 * NUM_DIGITS;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [DIV_W-1:0]      div_cnt;
  logic [IDX_W-1:0]      idx;
  logic [DIG_W-1:0]      shadow_dig;
  logic [NUM_DIGITS-1:0] shadow_dp;
  logic                  shadow_valid;

  logic                  tick_c;
  logic                  frame_end_c;
  logic                  load_c;
  logic [NUM_DIGITS-1:0] lead_blank_c;
  logic                  zero_above_c;
  logic [3:0]            cur_nib_c;
  logic                  cur_dp_c;
  logic                  cur_lead_c;
  logic                  cur_en_c;
  logic [7:0]            dec_seg_c;
  logic [7:0]            seg_next_c;
  logic [NUM_DIGITS-1:0] an_next_c;

  assign tick_c      = (div_cnt == DIV_LAST);
  assign frame_end_c = tick_c && (idx == IDX_LAST);
  assign load_c      = frame_end_c && upd_req;

  // Slot prescaler and digit index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      idx     <= '0;
    end else begin
      div_cnt <= tick_c ? '0 : div_cnt + DIV_W'(1);
      if (tick_c) idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
    end
  end

  // Shadow register only moves on a frame boundary so a frame never tears
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_dig   <= '0;
      shadow_dp    <= '0;
      shadow_valid <= 1'b0;
      upd_ack      <= 1'b0;
    end else begin
      upd_ack <= load_c;
      if (load_c) begin
        shadow_dig   <= digits;
        shadow_dp    <= dp_in;
        shadow_valid <= 1'b1;
      end
    end
  end

  // A digit is a leading zero when it and every digit above it are zero
  always_comb begin
    zero_above_c = 1'b1;
    lead_blank_c = '0;
    for (int i = int'(NUM_DIGITS) - 1; i >= 1; i--) begin
      zero_above_c    = zero_above_c & (shadow_dig[4*i +: 4] == 4'h0);
      lead_blank_c[i] = zero_above_c;
    end
  end

  always_comb begin
    cur_nib_c  = 4'h0;
    cur_dp_c   = 1'b0;
    cur_lead_c = 1'b0;
    cur_en_c   = 1'b0;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (idx == IDX_W'(i)) begin
        cur_nib_c  = shadow_dig[4*i +: 4];
        cur_dp_c   = shadow_dp[i];
        cur_lead_c = lead_blank_c[i];
        cur_en_c   = digit_en[i];
      end
    end
  end

  seg_nibble_decode u_decode (
    .nibble (cur_nib_c),
    .dp     (cur_dp_c),
    .blank  (lzb & cur_lead_c),
    .seg_c  (dec_seg_c)
  );

  // At most the current slot's anode is driven on
  always_comb begin
    seg_next_c = shadow_valid ? dec_seg_c : SEG_BLANK;
    an_next_c  = {NUM_DIGITS{AN_OFF}};
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (shadow_valid && cur_en_c && (idx == IDX_W'(i))) an_next_c[i] = AN_ON;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg <= SEG_BLANK;
      an  <= {NUM_DIGITS{AN_OFF}};
    end else begin
      seg <= seg_next_c;
      an  <= an_next_c;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver: time-based reference model feeds a queue,
// a negedge monitor pops and compares every cycle.
module tb_seg_scan_driver;

  localparam int unsigned ND    = 4;
  localparam int unsigned RD    = 4;
  localparam int          FRAME = int'(ND * RD);

  logic          clk = 1'b0;
  logic          rst_n;
  logic [4*ND-1:0] digits;
  logic [ND-1:0] dp_in;
  logic [ND-1:0] digit_en;
  logic          lzb;
  logic          upd_req;
  logic          upd_ack;
  logic [7:0]    seg;
  logic [ND-1:0] an;

  seg_scan_driver #(.NUM_DIGITS(ND), .REFRESH_DIV(RD)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .digits   (digits),
    .dp_in    (dp_in),
    .digit_en (digit_en),
    .lzb      (lzb),
    .upd_req  (upd_req),
    .upd_ack  (upd_ack),
    .seg      (seg),
    .an       (an)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]    seg;
    logic [ND-1:0] an;
    logic          ack;
    bit            seg_dc;
    int            k;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   mon_items = 0;

  // Reference state: clocks since reset release and the latched display contents
  int   k;
  int   m_dig [ND];
  bit   m_dp  [ND];
  bit   m_valid;

  task automatic check(input string name, input int kk, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s k=%0d got %0h expected %0h", name, kk, got, exp);
    end
  endtask

  function automatic logic [6:0] pat7(input int v);
    case (v)
      0: return 7'b0000001;
      1: return 7'b1001111;
      2: return 7'b0010010;
      3: return 7'b0000110;
      4: return 7'b1001100;
      5: return 7'b0100100;
      6: return 7'b0100000;
      7: return 7'b0001111;
      8: return 7'b0000000;
      9: return 7'b0000100;
`ifdef SEG_SCAN_HEX_DECODE_EN
      10: return 7'b0001000;
      11: return 7'b1100000;
      12: return 7'b0110001;
      13: return 7'b1000010;
      14: return 7'b0110000;
      15: return 7'b0111000;
`endif
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic bit shown(input int v);
`ifdef SEG_SCAN_HEX_DECODE_EN
    return v < 16;
`else
    return v < 10;
`endif
  endfunction

  function automatic logic [7:0] model_seg(input int i, input logic lz);
    int msd;
    msd = 0;
    for (int j = 0; j < int'(ND); j++) if (m_dig[j] != 0) msd = j;
    if (!m_valid) return 8'hFF;
    if (!shown(m_dig[i])) return 8'hFF;
    if (lz && i > msd) return {7'h7F, ~m_dp[i]};
    return {pat7(m_dig[i]), ~m_dp[i]};
  endfunction

  // Reference model: slot = floor(k/RD) mod ND, frame ends every ND*RD clocks
  always @(posedge clk or negedge rst_n) begin
    exp_t e;
    if (!rst_n) begin
      k = 0;
      m_valid = 1'b0;
      for (int j = 0; j < int'(ND); j++) begin
        m_dig[j] = 0;
        m_dp[j]  = 1'b0;
      end
      sb.delete();
      e.seg = 8'hFF; e.an = '1; e.ack = 1'b0; e.seg_dc = 1'b0; e.k = -1;
      sb.push_back(e);
    end else begin
      int slot;
      bit bnd;
      slot = (k / int'(RD)) % int'(ND);
      bnd  = (k % FRAME) == FRAME - 1;
      e.seg    = model_seg(slot, lzb);
      e.an     = '1;
      if (m_valid && digit_en[slot]) e.an[slot] = 1'b0;
      e.seg_dc = m_valid && !digit_en[slot];
      e.ack    = bnd && upd_req;
      e.k      = k;
      if (bnd && upd_req) begin
        for (int j = 0; j < int'(ND); j++) begin
          m_dig[j] = int'(digits[4*j +: 4]);
          m_dp[j]  = dp_in[j];
        end
        m_valid = 1'b1;
      end
      k++;
      sb.push_back(e);
    end
  end

  // Monitor: every clock presents a registered display word
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      mon_items++;
      if (!e.seg_dc) check("seg", e.k, 32'(seg), 32'(e.seg));
      check("an", e.k, 32'(an), 32'(e.an));
      check("upd_ack", e.k, 32'(upd_ack), 32'(e.ack));
      check("an_onehot", e.k, 32'($countones(~an) <= 1), 32'd1);
    end
  end

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    bit found;
    rst_n    = 1'b0;
    digits   = '0;
    dp_in    = '0;
    digit_en = '1;
    lzb      = 1'b0;
    upd_req  = 1'b0;
    run(3);
    rst_n = 1'b1;

    // Idle after reset: nothing loaded, display dark
    digits = 16'(($urandom));
    run(40);

    // First load and scan
    digits = 16'h1234; dp_in = '0; upd_req = 1'b1;
    run(FRAME);
    upd_req = 1'b0;
    run(2 * FRAME);

    // Leading-zero blanking on and off
    digits = 16'h0070; lzb = 1'b1; upd_req = 1'b1;
    run(FRAME);
    upd_req = 1'b0;
    run(2 * FRAME);
    lzb = 1'b0;
    run(2 * FRAME);

    // Slot enable and decimal point
    digits = 16'h1234; dp_in = 4'b0001; digit_en = 4'b1011; upd_req = 1'b1;
    run(FRAME);
    upd_req = 1'b0;
    run(2 * FRAME);

    // Input changes without a request must not reach the display
    digit_en = '1; dp_in = '0;
    digits = 16'h1234; upd_req = 1'b1;
    run(FRAME);
    upd_req = 1'b0;
    run(FRAME / 2);
    digits = 16'h5678;
    run(2 * FRAME);
    upd_req = 1'b1;
    run(FRAME);
    upd_req = 1'b0;
    run(2 * FRAME);

    // Randomised traffic, biased toward zero nibbles
    for (int it = 0; it < 60; it++) begin
      for (int j = 0; j < int'(ND); j++)
        digits[4*j +: 4] = ($urandom_range(0, 9) < 4) ? 4'h0 : 4'($urandom_range(0, 15));
      dp_in    = ND'($urandom);
      digit_en = ND'($urandom) | ND'($urandom);
      lzb      = 1'($urandom);
      upd_req  = ($urandom_range(0, 3) == 0);
      run(int'($urandom_range(1, 24)));
    end

    // Asynchronous reset in the middle of slot 2 with a lit display
    digit_en = '1; lzb = 1'b0; digits = 16'h1234; dp_in = '0; upd_req = 1'b1;
    run(FRAME + 2);
    upd_req = 1'b0;
    found = 1'b0;
    for (int t = 0; t < 200 && !found; t++) begin
      if (((k / int'(RD)) % int'(ND)) == 2 && (k % int'(RD)) == 1) found = 1'b1;
      else @(negedge clk);
    end
    check("slot2_reached", k, 32'(found), 32'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_seg", -1, 32'(seg), 32'hFF);
    check("async_rst_an", -1, 32'(an), 32'hF);
    check("async_rst_ack", -1, 32'(upd_ack), 32'd0);
    run(2);
    rst_n = 1'b1;

    // Hex nibble after reset: restart from slot 0, load at first boundary
    digits = 16'h000A; dp_in = '0; upd_req = 1'b1;
    run(FRAME);
    upd_req = 1'b0;
    run(2 * FRAME);
    lzb = 1'b1;
    run(FRAME);

    check("scoreboard_items", 0, 32'(mon_items > 1000), 32'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
